// File: rtl/spi_regfile_pkg.sv
// Shared constants and FSM encoding for the SPI byte-command register file.
package spi_regfile_pkg;
  localparam int          CMD_RW_BIT = 7;
  localparam int          ADDR_W     = 7;
  localparam logic [7:0]  ID_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;
endpackage

// File: rtl/spi_regfile_if.sv
// Byte stream between spislave (master side) and the register file (slave side).
interface spi_regfile_if;
  logic [7:0] rxdata;
  logic       rxready;
  logic       txready;
  logic [7:0] txdata;

  modport master (output rxdata, rxready, txready, input txdata);
  modport slave  (input rxdata, rxready, txready, output txdata);
endinterface

// File: rtl/spi_regfile_sync3.sv
// Three-flop synchroniser for asynchronous pin inputs; reset value is selectable.
module sync3 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [2:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr <= {3{RST_VAL}};
    else       sr <= {sr[1:0], d};
  end

  assign q = sr[2];
endmodule

// File: rtl/spi_regfile.sv
// SPI frame decoder: command byte {rw, addr} then auto-incrementing data bytes
// into R/W registers (regs_out) or back from regs_out / regs_in.
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter int         NREGS = 8,
  parameter logic [7:0] ID    = ID_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ss,
  spi_regfile_if.slave         bus,
  output logic [NREGS*8-1:0]   regs_out,
  input  logic [NREGS*8-1:0]   regs_in,
  output logic                 wr_stb,
  output logic [ADDR_W-1:0]    wr_addr
);
  logic ss_sync, sel, sel_q, sel_rise;

  // Synchroniser resets to "selected" and sel_q to 1 so a frame already in
  // progress when reset drops is never seen as a rising select.
  sync3 #(.RST_VAL(1'b0)) u_ss_sync (.clk(clk), .reset(reset), .d(ss), .q(ss_sync));

  assign sel      = ~ss_sync;
  assign sel_rise = sel & ~sel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_q <= 1'b1;
    else       sel_q <= sel;
  end

  state_t                  state, state_nxt;
  logic [ADDR_W-1:0]       addr, addr_nxt;
  logic [NREGS-1:0][7:0]   regs;
  logic                    latch_cmd, do_write, adv_read, load_rd, in_rw;
  logic [7:0]              rd_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (sel_rise) state_nxt = ST_CMD;
      ST_CMD:  if (bus.rxready)
                 state_nxt = bus.rxdata[CMD_RW_BIT] ? ST_READ : ST_WRITE;
      default: ;
    endcase
    if (!sel) state_nxt = ST_IDLE;
  end

  always_comb begin
    latch_cmd = sel && (state == ST_CMD)   && bus.rxready;
    do_write  = sel && (state == ST_WRITE) && bus.rxready;
    adv_read  = sel && (state == ST_READ)  && bus.txready;
    load_rd   = (latch_cmd && bus.rxdata[CMD_RW_BIT]) || adv_read;
    in_rw     = int'(addr) < NREGS;
    addr_nxt  = addr;
    if (latch_cmd)                addr_nxt = bus.rxdata[ADDR_W-1:0];
    else if (do_write || adv_read) addr_nxt = addr + 1'b1;
  end

  // Read mux looks at the address being loaded so txdata is ready one cycle on.
  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < NREGS; i++) begin
      if (addr_nxt == ADDR_W'(i))         rd_byte = regs[i];
      if (addr_nxt == ADDR_W'(NREGS + i)) rd_byte = regs_in[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      regs       <= '0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      bus.txdata <= ID;
    end else begin
      addr   <= addr_nxt;
      wr_stb <= do_write && in_rw;
      if (do_write && in_rw) wr_addr <= addr;
      for (int i = 0; i < NREGS; i++)
        if (do_write && addr == ADDR_W'(i)) regs[i] <= bus.rxdata;
      if (load_rd)                    bus.txdata <= rd_byte;
      else if (state_nxt == ST_WRITE) bus.txdata <= 8'h00;
      else if (state_nxt != ST_READ)  bus.txdata <= ID;
    end
  end

  assign regs_out = regs;
endmodule

// File: tb/tb_spi_regfile.sv
// Byte-level bench for spi_regfile: emulates spislave handshakes and checks
// against a frame-level model of the register map.
module tb_spi_regfile;
  localparam int NREGS = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ss = 1'b1;
  logic [NREGS*8-1:0] regs_out;
  logic [NREGS*8-1:0] regs_in = '0;
  logic              wr_stb;
  logic [6:0]        wr_addr;

  spi_regfile_if bus();

  spi_regfile #(.NREGS(NREGS), .ID(8'hA5)) dut (
    .clk(clk), .reset(reset), .ss(ss), .bus(bus),
    .regs_out(regs_out), .regs_in(regs_in),
    .wr_stb(wr_stb), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mregs [NREGS];
  logic [7:0] fb[$];
  logic [7:0] got[$];
  logic [7:0] exp_got[$];
  logic [6:0] exp_stb[$];
  logic [6:0] stb_q[$];

  always @(negedge clk) if (wr_stb) stb_q.push_back(wr_addr);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got %0d checks, required completion)", checks);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [6:0] a);
    int ai = int'(a);
    if (ai < NREGS)   return mregs[ai];
    if (ai < 2*NREGS) return regs_in[8*(ai-NREGS) +: 8];
    return 8'h00;
  endfunction

  function automatic logic [63:0] model_regs();
    logic [63:0] v = '0;
    for (int i = 0; i < NREGS; i++) v[8*i +: 8] = mregs[i];
    return v;
  endfunction

  // Expected master-received bytes and write strobes for frame fb.
  task automatic model_frame(input bit partial);
    logic       rw;
    logic [6:0] a;
    exp_got.delete(); exp_stb.delete();
    exp_got.push_back(8'hA5);
    rw = fb[0][7];
    a  = fb[0][6:0];
    for (int i = 1; i < fb.size(); i++) begin
      if (rw) begin
        exp_got.push_back(model_rd(a));
        a = a + 7'd1;
      end else begin
        exp_got.push_back(8'h00);
        if (!(partial && i == fb.size()-1)) begin
          if (int'(a) < NREGS) begin
            mregs[int'(a)] = fb[i];
            exp_stb.push_back(a);
          end
          a = a + 7'd1;
        end
      end
    end
  endtask

  task automatic pulse_tx();
    @(negedge clk);
    got.push_back(bus.txdata);
    bus.txready = 1'b1;
    @(negedge clk);
    bus.txready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    @(negedge clk);
    bus.rxdata  = d;
    bus.rxready = 1'b1;
    @(negedge clk);
    bus.rxready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // A partial last byte gets its txready but never an rxready.
  task automatic run_frame(input bit partial);
    @(negedge clk);
    ss = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < fb.size(); i++) begin
      pulse_tx();
      if (!(partial && i == fb.size()-1)) pulse_rx(fb[i]);
    end
    ss = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, " byte count"}, 64'(got.size()), 64'(exp_got.size()));
    n = (got.size() < exp_got.size()) ? got.size() : exp_got.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s tx[%0d]", tag, i), 64'(got[i]), 64'(exp_got[i]));
    chk({tag, " wr_stb count"}, 64'(stb_q.size()), 64'(exp_stb.size()));
    n = (stb_q.size() < exp_stb.size()) ? stb_q.size() : exp_stb.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s wr_addr[%0d]", tag, i), 64'(stb_q[i]), 64'(exp_stb[i]));
    chk({tag, " regs_out"}, regs_out, model_regs());
    got.delete(); stb_q.delete();
  endtask

  task automatic frame(input string tag, input bit partial);
    model_frame(partial);
    run_frame(partial);
    check_frame(tag);
  endtask

  initial begin
    bus.rxdata = 8'h00; bus.rxready = 1'b0; bus.txready = 1'b0;
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset txdata", 64'(bus.txdata), 64'hA5);
    chk("reset regs_out", regs_out, 64'h0);
    chk("reset wr_stb", 64'(wr_stb), 64'h0);
    chk("reset wr_addr", 64'(wr_addr), 64'h0);

    fb = '{8'h00};                frame("cmd only", 1'b0);
    fb = '{8'h02, 8'h11, 8'h22};  frame("write 2,3", 1'b0);
    chk("reg2", 64'(regs_out[23:16]), 64'h11);
    chk("reg3", 64'(regs_out[31:24]), 64'h22);

    regs_in[15:8]  = 8'h5C;
    regs_in[23:16] = 8'h3D;
    fb = '{8'h89, 8'h00, 8'h00};  frame("read 9", 1'b0);

    fb = '{8'h7F, 8'hEE, 8'h33};  frame("write wrap", 1'b0);
    chk("reg0 wrap", 64'(regs_out[7:0]), 64'h33);

    fb = '{8'h04, 8'h77};         frame("partial write", 1'b1);
    fb = '{8'h00};                frame("after partial", 1'b0);

    // Reset in the middle of a read frame, then more traffic before ss rises.
    @(negedge clk);
    ss = 1'b0;
    repeat (6) @(negedge clk);
    pulse_tx();
    pulse_rx(8'h82);
    pulse_tx();
    chk("pre-reset read", 64'(got[1]), 64'(mregs[2]));
    got.delete();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid reset txdata", 64'(bus.txdata), 64'hA5);
    chk("mid reset regs_out", regs_out, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    pulse_rx(8'h03);
    pulse_tx();
    pulse_rx(8'h44);
    chk("post reset tx", 64'(got[0]), 64'hA5);
    chk("post reset no stb", 64'(stb_q.size()), 64'h0);
    chk("post reset regs", regs_out, 64'h0);
    ss = 1'b1;
    repeat (6) @(negedge clk);
    got.delete(); stb_q.delete();
    fb = '{8'h01, 8'h9A};         frame("after reset write", 1'b0);

    for (int k = 0; k < 24; k++) begin
      int n;
      logic [7:0] cmd;
      regs_in = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        cmd = {1'b1, 7'($urandom_range(0, 127))};
        n   = $urandom_range(0, 4);
      end else begin
        cmd = {1'b0, 7'($urandom_range(0, NREGS-3))};
        n   = $urandom_range(1, 3);
      end
      fb.delete();
      fb.push_back(cmd);
      for (int j = 0; j < n; j++) fb.push_back(8'($urandom));
      frame($sformatf("rand%0d", k), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
